// File: rtl/hpm_event_collector.sv
// hpm_event_collector
//   Serialises per-cycle event increments (several occurrences of one event
//   may arrive in the same cycle) into a one-pulse-per-cycle event vector
//   for the HPM counters. Each event has a saturating backlog counter.
//   Any loss caused by saturation can be flagged in a sticky per-event bit.
//
//   Optional feature macro: HPM_EVT_LOST_TRACK_EN
//     defined   -> lost_o flags are tracked and cleared by lost_clr_i
//     undefined -> lost_o tied to 0, lost_clr_i ignored (loss is silent)
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   event_inc_i  packed increments; field j-1 carries the count for event j
//   clear_i      synchronous discard of all backlogs and pending pulses
//   lost_clr_i   synchronous clear of all lost_o flags
//   events_o     registered one-cycle event pulses, bit j for event j
//   lost_o       sticky per-event loss flag
//   busy_o       registered; high while any backlog is nonzero

// Per-event backlog lane.
module hpm_evt_lane #(
  parameter int INC_WIDTH  = 2,
  parameter int PEND_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [INC_WIDTH-1:0] inc_i,
  input  logic                 clear_i,
  input  logic                 lost_clr_i,
  output logic                 evt_o,
  output logic                 lost_o,
  output logic                 pend_nz_o
);
  localparam logic [PEND_WIDTH-1:0] PEND_MAX = {PEND_WIDTH{1'b1}};

  logic [PEND_WIDTH-1:0] pend_q, pend_d;
  logic [PEND_WIDTH:0]   total, total_m1;
  logic                  sat, evt_d;

  // total is one bit wider than pend so pend + inc never wraps.
  always_comb begin
    total    = {1'b0, pend_q} + (PEND_WIDTH+1)'(inc_i);
    total_m1 = total - 1'b1;
    sat      = !clear_i && (total != '0) && (total_m1 > {1'b0, PEND_MAX});
    evt_d    = !clear_i && (total != '0);
    pend_d   = '0;
    if (!clear_i && total != '0)
      pend_d = sat ? PEND_MAX : total_m1[PEND_WIDTH-1:0];
  end

  assign pend_nz_o = |pend_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q <= '0;
      evt_o  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      evt_o  <= evt_d;
    end
  end

`ifdef HPM_EVT_LOST_TRACK_EN
  // A saturation in the same cycle as lost_clr_i wins over the clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)           lost_o <= 1'b0;
    else if (sat)        lost_o <= 1'b1;
    else if (lost_clr_i) lost_o <= 1'b0;
  end
`else
  logic unused_lost;
  assign unused_lost = lost_clr_i ^ sat;
  assign lost_o      = 1'b0;
`endif
endmodule

module hpm_event_collector #(
  parameter int HPM_NUM_EVENTS = 28,
  parameter int INC_WIDTH      = 2,
  parameter int PEND_WIDTH     = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [HPM_NUM_EVENTS*INC_WIDTH-1:0] event_inc_i,
  input  logic                                clear_i,
  input  logic                                lost_clr_i,
  output logic [HPM_NUM_EVENTS:1]             events_o,
  output logic [HPM_NUM_EVENTS:1]             lost_o,
  output logic                                busy_o
);
  logic [HPM_NUM_EVENTS:1] pend_nz;

  for (genvar j = 1; j <= HPM_NUM_EVENTS; j++) begin : g_lane
    hpm_evt_lane #(
      .INC_WIDTH  (INC_WIDTH),
      .PEND_WIDTH (PEND_WIDTH)
    ) u_lane (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .inc_i      (event_inc_i[j*INC_WIDTH-1 -: INC_WIDTH]),
      .clear_i    (clear_i),
      .lost_clr_i (lost_clr_i),
      .evt_o      (events_o[j]),
      .lost_o     (lost_o[j]),
      .pend_nz_o  (pend_nz[j])
    );
  end

  // busy reflects the backlog state after this cycle's update.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) busy_o <= 1'b0;
    else       busy_o <= |pend_nz;
  end
endmodule

// File: tb/tb_hpm_event_collector.sv
module tb_hpm_event_collector;
  localparam int N  = 28;
  localparam int IW = 2;
  localparam int PW = 4;
  localparam int PMAX = (1 << PW) - 1;
`ifdef HPM_EVT_LOST_TRACK_EN
  localparam bit LOST_EN = 1'b1;
`else
  localparam bit LOST_EN = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [N*IW-1:0]   event_inc_i;
  logic              clear_i, lost_clr_i;
  logic [N:1]        events_o, lost_o;
  logic              busy_o;

  int total = 0;
  int bad   = 0;

  // reference state: plain integer backlog per event
  int  bl   [1:N];
  bit  ev_m [1:N];
  bit  lo_m [1:N];
  bit  busy_m;

  always #5 clk_i = ~clk_i;

  hpm_event_collector dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .event_inc_i (event_inc_i),
    .clear_i     (clear_i),
    .lost_clr_i  (lost_clr_i),
    .events_o    (events_o),
    .lost_o      (lost_o),
    .busy_o      (busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_inc(input int j, input int v);
    event_inc_i[(j-1)*IW +: IW] = IW'(v);
  endtask

  task automatic model_reset();
    for (int j = 1; j <= N; j++) begin bl[j] = 0; ev_m[j] = 0; lo_m[j] = 0; end
    busy_m = 0;
  endtask

  // Occurrences join the queue; one leaves per cycle as a pulse; anything
  // beyond the queue capacity is dropped and flagged.
  task automatic model_step();
    if (rst_i) begin model_reset(); return; end
    busy_m = 0;
    for (int j = 1; j <= N; j++) begin
      bit sat = 0;
      if (clear_i) begin
        bl[j] = 0; ev_m[j] = 0;
      end else begin
        bl[j] += int'(event_inc_i[(j-1)*IW +: IW]);
        ev_m[j] = (bl[j] > 0);
        if (bl[j] > 0) bl[j]--;
        if (bl[j] > PMAX) begin bl[j] = PMAX; sat = 1; end
      end
      if (!LOST_EN)        lo_m[j] = 0;
      else if (sat)        lo_m[j] = 1;
      else if (lost_clr_i) lo_m[j] = 0;
      if (bl[j] != 0) busy_m = 1;
    end
  endtask

  task automatic compare(input string tag);
    logic [N:1] ev_v, lo_v;
    for (int j = 1; j <= N; j++) begin ev_v[j] = ev_m[j]; lo_v[j] = lo_m[j]; end
    chk({tag, ".events"}, 64'(events_o), 64'(ev_v));
    chk({tag, ".lost"},   64'(lost_o),   64'(lo_v));
    chk({tag, ".busy"},   64'(busy_o),   64'(busy_m));
  endtask

  // one clock: model consumes the inputs the DUT samples, check 1ns later
  task automatic cycle(input string tag);
    @(posedge clk_i);
    model_step();
    #1;
    compare(tag);
  endtask

  task automatic idle_inputs();
    event_inc_i = '0; clear_i = 0; lost_clr_i = 0;
  endtask

  initial begin
    int cnt, first, last, busy_hi;
    model_reset();
    idle_inputs();
    rst_i = 1;
    for (int j = 1; j <= N; j++) set_inc(j, 3);
    #2;
    chk("rst.async.events", 64'(events_o), 64'(0));
    chk("rst.async.busy",   64'(busy_o),   64'(0));
    repeat (3) cycle("rst.hold");
    #2; rst_i = 0; idle_inputs();
    repeat (3) cycle("rst.release");

    // single event
    set_inc(1, 1);
    cycle("single.c0");
    #1 idle_inputs();
    cnt = 0;
    chk("single.ev1.c1", 64'(events_o[1]), 64'(1));
    repeat (4) begin cycle("single.drain"); cnt += int'(events_o[1]); end
    chk("single.count_after", 64'(cnt), 64'(0));

    // burst without loss: 18 pulses, busy 1..17
    cnt = 0; busy_hi = 0; first = -1; last = -1;
    for (int c = 0; c < 24; c++) begin
      if (c < 6) set_inc(5, 3); else set_inc(5, 0);
      cycle("burst");
      if (events_o[5]) begin cnt++; if (first < 0) first = c + 1; last = c + 1; end
      busy_hi += int'(busy_o);
      if (c == 17) chk("burst.busy_c18", 64'(busy_o), 64'(0));
    end
    chk("burst.count", 64'(cnt), 64'(18));
    chk("burst.first", 64'(first), 64'(1));
    chk("burst.last",  64'(last), 64'(18));
    chk("burst.busy_cycles", 64'(busy_hi), 64'(17));
    chk("burst.lost5", 64'(lost_o[5]), 64'(0));

    // clear during drain at backlog 12
    for (int c = 0; c < 6; c++) begin set_inc(5, 3); cycle("clr.fill"); end
    set_inc(5, 2); clear_i = 1;
    cycle("clr.cycle");
    chk("clr.ev5",  64'(events_o[5]), 64'(0));
    chk("clr.busy", 64'(busy_o), 64'(0));
    idle_inputs();
    repeat (2) cycle("clr.after");

    // saturation on event 28
    cnt = 0; first = -1; last = -1;
    for (int c = 0; c < 30; c++) begin
      if (c < 10) set_inc(28, 3); else set_inc(28, 0);
      cycle("sat");
      if (events_o[28]) begin cnt++; if (first < 0) first = c + 1; last = c + 1; end
      if (c == 6) chk("sat.lost_c7", 64'(lost_o[28]), 64'(0));
      if (c == 7) chk("sat.lost_c8", 64'(lost_o[28]), 64'(LOST_EN));
    end
    chk("sat.count", 64'(cnt), 64'(25));
    chk("sat.first", 64'(first), 64'(1));
    chk("sat.last",  64'(last), 64'(25));
    chk("sat.lost_hold", 64'(lost_o[28]), 64'(LOST_EN));
    lost_clr_i = 1; cycle("sat.lostclr");
    lost_clr_i = 0;
    chk("sat.lost_cleared", 64'(lost_o[28]), 64'(0));

    // clear/set collision: event 10 lost set earlier, event 3 saturates
    for (int c = 0; c < 8; c++) begin set_inc(10, 3); cycle("coll.sat10"); end
    set_inc(10, 0);
    chk("coll.lost10_set", 64'(lost_o[10]), 64'(LOST_EN));
    for (int c = 0; c < 7; c++) begin set_inc(3, 3); cycle("coll.fill3"); end
    set_inc(3, 3); lost_clr_i = 1;
    cycle("coll.cycle");
    chk("coll.lost3",  64'(lost_o[3]),  64'(LOST_EN));
    chk("coll.lost10", 64'(lost_o[10]), 64'(0));
    idle_inputs();
    repeat (20) cycle("coll.drain");

    // randomized traffic with varying density
    for (int blk = 0; blk < 8; blk++) begin
      int dens = $urandom_range(5, 90);
      for (int c = 0; c < 50; c++) begin
        for (int j = 1; j <= N; j++)
          set_inc(j, ($urandom_range(0, 99) < dens) ? $urandom_range(1, 3) : 0);
        clear_i    = ($urandom_range(0, 99) < 2);
        lost_clr_i = ($urandom_range(0, 99) < 5);
        cycle("rand");
      end
    end

    // asynchronous reset mid-drain
    idle_inputs();
    for (int c = 0; c < 4; c++) begin set_inc(7, 3); cycle("arst.fill"); end
    idle_inputs();
    cycle("arst.pre");
    chk("arst.busy_pre", 64'(busy_o), 64'(1));
    #2 rst_i = 1;
    #1;
    model_reset();
    compare("arst.now");
    cycle("arst.held");
    #2 rst_i = 0;
    repeat (3) cycle("arst.after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
